// File: rtl/mmix_defs.sv
// rtl/mmix_defs.sv - shared MMIX memory size codes, arbiter states and big-endian lane helpers
package mmix_defs;

    typedef enum logic [1:0] {
        SZ_BYTE  = 2'd0,
        SZ_WYDE  = 2'd1,
        SZ_TETRA = 2'd2,
        SZ_OCTA  = 2'd3
    } size_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CMD,
        ST_RDWAIT,
        ST_RESP
    } arb_state_e;

    // Lowest byte lane of the field: the offset is first aligned down to the access size.
    function automatic logic [2:0] lane_lo(input size_e size, input logic [2:0] offset);
        logic [3:0] nbytes;
        logic [3:0] kal;
        nbytes = 4'd1 << size;
        kal    = {1'b0, offset & ~3'(nbytes - 4'd1)};
        return 3'(4'd8 - kal - nbytes);
    endfunction

    function automatic logic [7:0] lane_enable(input size_e size, input logic [2:0] offset);
        logic [7:0] mask;
        case (size)
            SZ_BYTE:  mask = 8'h01;
            SZ_WYDE:  mask = 8'h03;
            SZ_TETRA: mask = 8'h0F;
            default:  mask = 8'hFF;
        endcase
        return mask << lane_lo(size, offset);
    endfunction

    function automatic logic [5:0] lane_shift(input size_e size, input logic [2:0] offset);
        return {lane_lo(size, offset), 3'b000};
    endfunction

    function automatic logic [63:0] field_mask(input size_e size);
        case (size)
            SZ_BYTE:  return 64'h0000_0000_0000_00FF;
            SZ_WYDE:  return 64'h0000_0000_0000_FFFF;
            SZ_TETRA: return 64'h0000_0000_FFFF_FFFF;
            default:  return 64'hFFFF_FFFF_FFFF_FFFF;
        endcase
    endfunction

endpackage

// File: rtl/mem_lane_align.sv
// rtl/mem_lane_align.sv - big-endian lane positioning of store data, byteenables and load extraction
module mem_lane_align
    import mmix_defs::*;
(
    input  size_e       size,
    input  logic [2:0]  offset,
    input  logic [63:0] wdata_in,
    input  logic [63:0] rdata_in,
    output logic [7:0]  byteenable,
    output logic [63:0] wdata_out,
    output logic [63:0] rdata_out
);

    logic [63:0] mask;
    logic [5:0]  shift;

    assign mask       = field_mask(size);
    assign shift      = lane_shift(size, offset);
    assign byteenable = lane_enable(size, offset);
    assign wdata_out  = (wdata_in & mask) << shift;
    assign rdata_out  = (rdata_in >> shift) & mask;

endmodule

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - fetch / load-store arbiter onto one 64-bit Avalon-MM bus
// MEM_PORT_ARBITER_RR_EN selects round-robin arbitration; default is data-over-fetch priority.
module mem_port_arbiter
    import mmix_defs::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [63:0]       if_address,
    input  logic [1:0]        if_datasize,
    input  logic              if_read,
    output logic [63:0]       if_readdata,
    output logic              if_done,
    input  logic [63:0]       d_address,
    input  logic [1:0]        d_datasize,
    input  logic              d_read,
    input  logic              d_write,
    input  logic [63:0]       d_writedata,
    output logic [63:0]       d_readdata,
    output logic              d_done,
    output logic [ADDR_W-1:0] avm_address,
    output logic [7:0]        avm_byteenable,
    output logic              avm_read,
    output logic              avm_write,
    output logic [63:0]       avm_writedata,
    input  logic [63:0]       avm_readdata,
    input  logic              avm_waitrequest,
    input  logic              avm_readdatavalid
);

    arb_state_e        state_q, state_d;
    logic              sel_data_q, sel_data_d;
    logic              is_wr_q, is_wr_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    size_e             size_q, size_d;
    logic [2:0]        offset_q, offset_d;
    logic [63:0]       wdata_q, wdata_d;
    logic [63:0]       if_rdata_q, if_rdata_d;
    logic [63:0]       d_rdata_q, d_rdata_d;

    logic              d_req;
    logic              take_data;
    logic              in_cmd;
    logic [7:0]        lane_be;
    logic [63:0]       lane_wdata;
    logic [63:0]       lane_rdata;
    logic              unused_addr_bits;

    assign d_req            = d_read | d_write;
    assign unused_addr_bits = ^{if_address[63:ADDR_W], d_address[63:ADDR_W]};

`ifdef MEM_PORT_ARBITER_RR_EN
    logic last_data_q, last_data_d;

    // Contested grant goes to the port that did not win last time.
    assign take_data = d_req & (~if_read | ~last_data_q);

    always_comb begin
        last_data_d = last_data_q;
        if (state_q == ST_IDLE && (d_req || if_read)) begin
            last_data_d = take_data;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            last_data_q <= 1'b1;
        end else begin
            last_data_q <= last_data_d;
        end
    end
`else
    assign take_data = d_req;
`endif

    always_comb begin
        state_d    = state_q;
        sel_data_d = sel_data_q;
        is_wr_d    = is_wr_q;
        addr_d     = addr_q;
        size_d     = size_q;
        offset_d   = offset_q;
        wdata_d    = wdata_q;
        if_rdata_d = if_rdata_q;
        d_rdata_d  = d_rdata_q;
        case (state_q)
            ST_IDLE: begin
                if (d_req || if_read) begin
                    state_d    = ST_CMD;
                    sel_data_d = take_data;
                    // A simultaneous read and write on the data port resolves to the read.
                    is_wr_d    = take_data & d_write & ~d_read;
                    wdata_d    = d_writedata;
                    if (take_data) begin
                        addr_d   = {d_address[ADDR_W-1:3], 3'b000};
                        size_d   = size_e'(d_datasize);
                        offset_d = d_address[2:0];
                    end else begin
                        addr_d   = {if_address[ADDR_W-1:3], 3'b000};
                        size_d   = size_e'(if_datasize);
                        offset_d = if_address[2:0];
                    end
                end
            end
            ST_CMD: begin
                if (!avm_waitrequest) begin
                    state_d = is_wr_q ? ST_RESP : ST_RDWAIT;
                end
            end
            ST_RDWAIT: begin
                if (avm_readdatavalid) begin
                    state_d = ST_RESP;
                    if (sel_data_q) begin
                        d_rdata_d = lane_rdata;
                    end else begin
                        if_rdata_d = lane_rdata;
                    end
                end
            end
            ST_RESP: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ST_IDLE;
            sel_data_q <= 1'b0;
            is_wr_q    <= 1'b0;
            addr_q     <= '0;
            size_q     <= SZ_BYTE;
            offset_q   <= 3'd0;
            wdata_q    <= 64'd0;
            if_rdata_q <= 64'd0;
            d_rdata_q  <= 64'd0;
        end else begin
            state_q    <= state_d;
            sel_data_q <= sel_data_d;
            is_wr_q    <= is_wr_d;
            addr_q     <= addr_d;
            size_q     <= size_d;
            offset_q   <= offset_d;
            wdata_q    <= wdata_d;
            if_rdata_q <= if_rdata_d;
            d_rdata_q  <= d_rdata_d;
        end
    end

    mem_lane_align u_align (
        .size       (size_q),
        .offset     (offset_q),
        .wdata_in   (wdata_q),
        .rdata_in   (avm_readdata),
        .byteenable (lane_be),
        .wdata_out  (lane_wdata),
        .rdata_out  (lane_rdata)
    );

    // Bus outputs are driven from latched values only in CMD, so they stay stable through stalls.
    assign in_cmd         = (state_q == ST_CMD);
    assign avm_read       = in_cmd & ~is_wr_q;
    assign avm_write      = in_cmd & is_wr_q;
    assign avm_address    = in_cmd ? addr_q : '0;
    assign avm_byteenable = in_cmd ? lane_be : 8'h00;
    assign avm_writedata  = avm_write ? lane_wdata : 64'd0;

    assign if_done     = (state_q == ST_RESP) & ~sel_data_q;
    assign d_done      = (state_q == ST_RESP) & sel_data_q;
    assign if_readdata = if_rdata_q;
    assign d_readdata  = d_rdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - self-checking bench for mem_port_arbiter with a behavioural bus and lane model
module tb_mem_port_arbiter;

    localparam int ADDR_W = 32;

    logic              clk = 1'b0;
    logic              reset_n = 1'b0;
    logic [63:0]       if_address = 64'd0;
    logic [1:0]        if_datasize = 2'd0;
    logic              if_read = 1'b0;
    logic [63:0]       if_readdata;
    logic              if_done;
    logic [63:0]       d_address = 64'd0;
    logic [1:0]        d_datasize = 2'd0;
    logic              d_read = 1'b0;
    logic              d_write = 1'b0;
    logic [63:0]       d_writedata = 64'd0;
    logic [63:0]       d_readdata;
    logic              d_done;
    logic [ADDR_W-1:0] avm_address;
    logic [7:0]        avm_byteenable;
    logic              avm_read;
    logic              avm_write;
    logic [63:0]       avm_writedata;
    logic [63:0]       avm_readdata;
    logic              avm_waitrequest;
    logic              avm_readdatavalid;

    int          vectors = 0;
    int          miscompares = 0;
    int          stall_cfg = 0;
    int          rlat_cfg = 1;
    logic [63:0] rd_word_cfg = 64'd0;
    logic        inj_rdv = 1'b0;
    logic [63:0] inj_data = 64'd0;
    int          stall_cnt = 0;
    int          rdv_cnt = 0;
    logic        rdv_q = 1'b0;
    logic [63:0] rdq_data = 64'd0;
    int          wr_count = 0;
    logic [63:0] last_wr_data = 64'd0;
    logic [7:0]  last_wr_be = 8'd0;
    bit          model_last_d = 1'b1;
    bit          exp_first;

    mem_port_arbiter #(.ADDR_W(ADDR_W)) dut (
        .clk               (clk),
        .reset_n           (reset_n),
        .if_address        (if_address),
        .if_datasize       (if_datasize),
        .if_read           (if_read),
        .if_readdata       (if_readdata),
        .if_done           (if_done),
        .d_address         (d_address),
        .d_datasize        (d_datasize),
        .d_read            (d_read),
        .d_write           (d_write),
        .d_writedata       (d_writedata),
        .d_readdata        (d_readdata),
        .d_done            (d_done),
        .avm_address       (avm_address),
        .avm_byteenable    (avm_byteenable),
        .avm_read          (avm_read),
        .avm_write         (avm_write),
        .avm_writedata     (avm_writedata),
        .avm_readdata      (avm_readdata),
        .avm_waitrequest   (avm_waitrequest),
        .avm_readdatavalid (avm_readdatavalid)
    );

    always #5 clk = ~clk;

    // Bus slave: stalls each command stall_cfg cycles, returns rd_word_cfg rlat_cfg cycles after acceptance.
    assign avm_waitrequest   = (avm_read || avm_write) && (stall_cnt < stall_cfg);
    assign avm_readdatavalid = rdv_q | inj_rdv;
    assign avm_readdata      = inj_rdv ? inj_data : rdq_data;

    always @(posedge clk) begin
        rdv_q <= 1'b0;
        if (rdv_cnt != 0) begin
            rdv_cnt <= rdv_cnt - 1;
            rdv_q   <= (rdv_cnt == 1);
        end
        if (avm_read || avm_write) begin
            if (stall_cnt < stall_cfg) begin
                stall_cnt <= stall_cnt + 1;
            end else begin
                stall_cnt <= 0;
                if (avm_write) begin
                    wr_count     <= wr_count + 1;
                    last_wr_data <= avm_writedata;
                    last_wr_be   <= avm_byteenable;
                end else begin
                    rdq_data <= rd_word_cfg;
                    if (rlat_cfg <= 1) rdv_q <= 1'b1;
                    else rdv_cnt <= rlat_cfg - 1;
                end
            end
        end
    end

    // Reference model: byte j of an octa sits in bits [63-8j -: 8]; values are big-endian.
    function automatic logic [7:0] m_be(input logic [1:0] sz, input logic [63:0] a);
        int n, k;
        logic [7:0] be;
        n  = 1 << sz;
        k  = (int'(a[2:0]) / n) * n;
        be = 8'd0;
        for (int i = 0; i < n; i++) be[7-k-i] = 1'b1;
        return be;
    endfunction

    function automatic logic [63:0] m_wdata(input logic [1:0] sz, input logic [63:0] a, input logic [63:0] wd);
        int n, k;
        logic [63:0] w;
        n = 1 << sz;
        k = (int'(a[2:0]) / n) * n;
        w = 64'd0;
        for (int i = 0; i < n; i++) w |= ((wd >> (8 * (n - 1 - i))) & 64'hFF) << (56 - 8 * (k + i));
        return w;
    endfunction

    function automatic logic [63:0] m_rdata(input logic [1:0] sz, input logic [63:0] a, input logic [63:0] word);
        int n, k;
        logic [63:0] r;
        n = 1 << sz;
        k = (int'(a[2:0]) / n) * n;
        r = 64'd0;
        for (int i = 0; i < n; i++) r |= ((word >> (56 - 8 * (k + i))) & 64'hFF) << (8 * (n - 1 - i));
        return r;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_quiet(input string tag);
        chk({tag, ".cmd"}, {62'd0, avm_read, avm_write}, 64'd0);
        chk({tag, ".done"}, {62'd0, if_done, d_done}, 64'd0);
        chk({tag, ".addr_be"}, {24'd0, avm_address, avm_byteenable}, 64'd0);
        chk({tag, ".wdata"}, avm_writedata, 64'd0);
    endtask

    // kind: 0 fetch read, 1 data read, 2 data write, 3 data read+write (read must win)
    task automatic txn(input int kind, input logic [63:0] addr, input logic [1:0] sz, input logic [63:0] wd,
                       input int stall, input int rlat, input logic [63:0] word, input string tag);
        int cyc, exp_lat, wr0;
        bit seen, is_wr;
        logic [ADDR_W-1:0] ea;
        is_wr = (kind == 2);
        ea = addr[ADDR_W-1:0];
        ea[2:0] = 3'd0;
        stall_cfg = stall;
        rlat_cfg = rlat;
        rd_word_cfg = word;
        wr0 = wr_count;
        @(posedge clk);
        #1;
        if (kind == 0) begin
            if_address = addr; if_datasize = sz; if_read = 1'b1;
        end else begin
            d_address = addr; d_datasize = sz; d_writedata = wd;
            d_read = (kind != 2);
            d_write = (kind >= 2);
        end
        cyc = 0;
        seen = 1'b0;
        while (!seen && cyc < 40) begin
            @(posedge clk);
            cyc++;
            @(negedge clk);
            if (avm_read || avm_write) begin
                chk({tag, ".cmd"}, {62'd0, avm_write, avm_read}, is_wr ? 64'd2 : 64'd1);
                chk({tag, ".addr"}, 64'(avm_address), 64'(ea));
                chk({tag, ".be"}, 64'(avm_byteenable), 64'(m_be(sz, addr)));
                if (is_wr) chk({tag, ".wdata"}, avm_writedata, m_wdata(sz, addr, wd));
            end
            if (if_done || d_done) seen = 1'b1;
        end
        chk({tag, ".port"}, {62'd0, if_done, d_done}, (kind == 0) ? 64'd2 : 64'd1);
        exp_lat = is_wr ? 2 + stall : 3 + stall + rlat - 1;
        chk({tag, ".latency"}, 64'(cyc), 64'(exp_lat));
        if (is_wr) begin
            chk({tag, ".nwrites"}, 64'(wr_count), 64'(wr0 + 1));
        end else begin
            chk({tag, ".nwrites"}, 64'(wr_count), 64'(wr0));
            chk({tag, ".rdata"}, (kind == 0) ? if_readdata : d_readdata, m_rdata(sz, addr, word));
        end
        @(posedge clk);
        #1;
        if_read = 1'b0; d_read = 1'b0; d_write = 1'b0;
        @(negedge clk);
        chk_quiet({tag, ".after"});
    endtask

    task automatic arb_round(input string tag, input bit exp_first_data);
        int cyc, ndone, second_cyc;
        bit first_d, drop_d, drop_f;
        logic [63:0] word;
        word = {$urandom, $urandom};
        stall_cfg = 0;
        rlat_cfg = 1;
        rd_word_cfg = word;
        @(posedge clk);
        #1;
        if_address = 64'h0000_0000_0000_8000; if_datasize = 2'd3;
        d_address = 64'h0000_0000_0000_9008; d_datasize = 2'd3;
        d_write = 1'b0; if_read = 1'b1; d_read = 1'b1;
        cyc = 0; ndone = 0; second_cyc = 0;
        first_d = 1'b0; drop_d = 1'b0; drop_f = 1'b0;
        while (ndone < 2 && cyc < 40) begin
            @(posedge clk);
            cyc++;
            #1;
            if (drop_d) d_read = 1'b0;
            if (drop_f) if_read = 1'b0;
            drop_d = 1'b0;
            drop_f = 1'b0;
            @(negedge clk);
            if (d_done) begin
                if (ndone == 0) first_d = 1'b1;
                drop_d = 1'b1;
                ndone++;
            end
            if (if_done) begin
                if (ndone == 0) first_d = 1'b0;
                drop_f = 1'b1;
                ndone++;
            end
            if (ndone == 2) second_cyc = cyc;
        end
        @(posedge clk);
        #1;
        if_read = 1'b0; d_read = 1'b0;
        chk({tag, ".first_is_data"}, 64'(first_d), 64'(exp_first_data));
        chk({tag, ".completions"}, 64'(ndone), 64'd2);
        chk({tag, ".loser_latency"}, 64'(second_cyc), 64'd7);
        chk({tag, ".if_rdata"}, if_readdata, word);
        chk({tag, ".d_rdata"}, d_readdata, word);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        reset_n = 1'b1;
        @(negedge clk);
        chk_quiet("reset");
        chk("reset.if_rdata", if_readdata, 64'd0);
        chk("reset.d_rdata", d_readdata, 64'd0);

        for (int r = 0; r < 2; r++) begin
`ifdef MEM_PORT_ARBITER_RR_EN
            exp_first = !model_last_d;
`else
            exp_first = 1'b1;
`endif
            arb_round($sformatf("arb%0d", r), exp_first);
            model_last_d = !exp_first;
        end

        txn(1, 64'h1000, 2'd3, 64'd0, 0, 1, 64'h0123_4567_89AB_CDEF, "octa_rd");
        chk("octa_rd.value", d_readdata, 64'h0123_4567_89AB_CDEF);

        txn(2, 64'h1005, 2'd0, 64'hDEAD_BEEF_1234_565A, 3, 1, 64'd0, "byte_wr");
        chk("byte_wr.bus_data", last_wr_data, 64'h0000_0000_005A_0000);
        chk("byte_wr.bus_be", 64'(last_wr_be), 64'h04);

        txn(1, 64'h2006, 2'd2, 64'd0, 0, 1, 64'h1122_3344_AABB_CCDD, "tetra_rd");
        chk("tetra_rd.value", d_readdata, 64'h0000_0000_AABB_CCDD);

        txn(3, 64'h3003, 2'd1, 64'h0000_0000_0000_BEEF, 1, 2, 64'h0102_0304_0506_0708, "rw_conflict");

        for (int i = 0; i < 24; i++) begin
            txn($urandom_range(0, 3), {$urandom, $urandom}, 2'($urandom_range(0, 3)), {$urandom, $urandom},
                $urandom_range(0, 2), $urandom_range(1, 3), {$urandom, $urandom}, $sformatf("rnd%0d", i));
        end

        // Reset while waiting for read data; the late readdatavalid must be ignored.
        stall_cfg = 0;
        rlat_cfg = 3;
        rd_word_cfg = 64'hCAFE_F00D_1234_5678;
        @(posedge clk);
        #1;
        d_address = 64'h5000; d_datasize = 2'd3; d_read = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1;
        reset_n = 1'b0;
        d_read = 1'b0;
        @(negedge clk);
        chk_quiet("in_reset");
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk);
            #1;
            inj_rdv = (c == 2);
            inj_data = 64'h5555_AAAA_5555_AAAA;
            @(negedge clk);
            chk_quiet($sformatf("post_reset%0d", c));
            chk($sformatf("post_reset%0d.d_rdata", c), d_readdata, 64'd0);
        end
        inj_rdv = 1'b0;

        txn(2, 64'h4003, 2'd1, 64'h0000_0000_0000_C3A5, 0, 1, 64'd0, "wr_after_reset");
        chk("wr_after_reset.bus_be", 64'(last_wr_be), 64'h30);
        chk("wr_after_reset.bus_data", last_wr_data, 64'h0000_C3A5_0000_0000);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Shares the single 64-bit data-memory bus (Avalon-MM master, DE0 SDRAM/on-chip RAM) between the instruction-fetch port and the load/store port of the execution unit. Accepts level-held read/write requests with MMIX size codes. Converts each to one octabyte-aligned bus transaction with big-endian byte lanes. Returns right-justified, zero-extended read data with a one-cycle `done` pulse.

## Interface
- `ADDR_W`, default 32: number of byte-address bits driven on the bus; requester address bits above `ADDR_W-1` are ignored.
- `clk`  in  1  clock
- `reset_n`  in  1  asynchronous, active-low reset
- `if_address`  in  64  fetch byte address
- `if_datasize`  in  2  size code: 0 byte, 1 wyde, 2 tetra, 3 octa
- `if_read`  in  1  fetch read request, held until `if_done`
- `if_readdata`  out  64  right-justified, zero-extended read data; valid with `if_done`
- `if_done`  out  1  one-cycle completion pulse
- `d_address`  in  64  load/store byte address
- `d_datasize`  in  2  size code, same encoding as `if_datasize`
- `d_read`  in  1  data read request, held until `d_done`
- `d_write`  in  1  data write request, held until `d_done`
- `d_writedata`  in  64  right-justified store value
- `d_readdata`  out  64  right-justified, zero-extended read data; valid with `d_done`
- `d_done`  out  1  one-cycle completion pulse
- `avm_address`  out  ADDR_W  octa-aligned byte address (bits [2:0] = 0)
- `avm_byteenable`  out  8  bus lane enables
- `avm_read`, `avm_write`  out  1 each  bus commands
- `avm_writedata`  out  64  lane-positioned store data
- `avm_readdata`  in  64  bus read data
- `avm_waitrequest`  in  1  bus stall
- `avm_readdatavalid`  in  1  bus read data valid

## Operation
- States:
  - IDLE: no request in flight.
  - CMD: command driven on the bus.
  - RDWAIT: read command accepted, waiting for data.
  - RESP: completion cycle.
- IDLE with any request pending: latch winner, address, size and write data; go to CMD.
- Arbitration: without the config macro, the data port has fixed priority over fetch.
- Same-port conflict: if `d_read` and `d_write` are both high, the read is taken and the write is ignored.
- Lane mapping is big-endian. With octa offset `k = addr[2:0]` aligned down to the size, `k' = k & ~(2^size-1)`:
  - The field occupies bits [63-8k' : 64-8k'-8·2^size].
  - `avm_byteenable` has bits 7-k' down to 8-k'-2^size set. Examples: byte at offset 0 gives 8'h80; tetra at offset 4 gives 8'h0F; octa gives 8'hFF.
- Write data is `d_writedata` low 8·2^size bits, shifted into the field; all other lanes are 0.
- Read data is the field shifted down to bit 0 and zero-extended. The load/store unit performs sign extension.
- CMD: hold `avm_read` or `avm_write` and all bus outputs stable while `avm_waitrequest`=1.
  - Write accepted: go to RESP.
  - Read accepted: go to RDWAIT.
- RDWAIT: on `avm_readdatavalid`, register the extracted data and go to RESP.
- RESP: pulse the granted port's `done` for exactly one cycle; next state IDLE.
  - The requester drops its request in the cycle after `done`, so IDLE never re-grants a completed request.
- A `avm_readdatavalid` arriving in IDLE, CMD or RESP is ignored. This covers stale data after a reset.
- Reset (any state, asynchronous): go to IDLE.
  - `avm_read`=0, `avm_write`=0, `avm_byteenable`=0, `avm_address`=0, `avm_writedata`=0.
  - `if_done`=0, `d_done`=0, `if_readdata`=0, `d_readdata`=0, round-robin pointer reset to "data last granted".

## Timing
- Write latency, request high to `done`: 1 (grant) + bus wait cycles + 1. Zero-wait write: `done` 2 cycles after request.
- Read latency: grant, CMD, RDWAIT (≥1 cycle until readdatavalid), RESP. Zero-wait bus with 1-cycle read latency: `done` 3 cycles after request.
- `*_readdata` is registered and holds its value until the next read for that port completes.
- Only one transaction is outstanding; the bus is never pipelined.
- The losing port stays pending and is granted in the IDLE cycle after the winner's RESP.

## Configuration
- `MEM_PORT_ARBITER_RR_EN` defined: round-robin arbitration.
  - When both ports request in IDLE, the port not granted last wins.
  - A single requester always wins.
- Macro undefined: fixed priority, data port over fetch; no pointer register exists.

## Structure
- Shared package (`mmix_defs`) holds:
  - the size-code enum (BYTE/WYDE/TETRA/OCTA);
  - the arbiter state enum;
  - functions `lane_enable(size, offset)` returning 8 bits, and `lane_shift(size, offset)` returning the bit shift.
- One sub-module, `mem_lane_align`: combinational write-data positioning, byteenable generation and read-data extraction. Instantiated once on the latched request.

## Test plan
- Octa read at `d_address`=0x1000, zero-wait bus, `avm_readdata`=0x0123456789ABCDEF → `avm_byteenable`=8'hFF, `d_done` 3 cycles after request, `d_readdata`=0x0123456789ABCDEF.
- Byte write at 0x1005, `d_writedata`=0x...5A, `avm_waitrequest` high 3 cycles → `avm_address`=0x1000, `avm_byteenable`=8'h04, `avm_writedata`=0x0000_0000_005A_0000, bus outputs stable throughout stall, one `d_done` pulse.
- Tetra read at 0x2006, `avm_readdata`=0x11223344_AABBCCDD → offset aligned to 4, `avm_byteenable`=8'h0F, `d_readdata`=0x00000000_AABBCCDD.
- `if_read` and `d_read` asserted in the same cycle, twice back to back:
  - macro off → data, fetch, data, fetch order follows the request drop/re-raise pattern;
  - macro on → grants alternate, fetch first after reset.
- Reset asserted in RDWAIT, then `avm_readdatavalid` pulsed after release → no `done` pulse, state IDLE, all outputs 0.
